// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and defaults for the UART transmit arbiter (rev 1.0).
`default_nettype none

package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2
  } arb_state_e;

  localparam logic [15:0] CLKS_PER_BIT       = 16'd868;
  localparam int          DEF_NUM_REQ        = 4;
  localparam int          DEF_TIMEOUT_CYCLES = 4096;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr_i (rev 1.0).
`default_nettype none

module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     pick_o,
  output logic             any_o
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // One extra bit in the sum keeps ptr+offset exact before the modulo fold.
  always_comb begin
    pick_o = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr_i} + (PTR_W+1)'(i);
      if (sum >= (PTR_W+1)'(N)) begin
        sum = sum - (PTR_W+1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx among NUM_REQ byte streams,
// with eviction of requesters that stall mid-packet (rev 1.0).
`default_nettype none

module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [8*NUM_REQ-1:0]   i_req_byte,
  input  logic [NUM_REQ-1:0]     i_req_last,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_tx_dv,
  output logic [7:0]             o_tx_byte,
  input  logic                   i_tx_done,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic                   o_busy,
  output logic                   o_timeout_err,
  input  logic                   i_err_clr
);

  localparam int               PTR_W    = $clog2(NUM_REQ);
  localparam logic [15:0]      TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   gidx_q, gidx_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic               last_q, last_d;
  logic               dv_q, dv_d;
  logic               err_q, err_d;
  logic [7:0]         byte_q, byte_d;

  logic [NUM_REQ-1:0] pick;
  logic               any_req;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   ptr_next;
  logic [7:0]         sel_byte;
  logic               sel_last;
  logic               sel_valid;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req_i  (i_req_valid),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (any_req)
  );

  // Grant is one-hot, so OR-ing the masked lanes acts as the data mux.
  always_comb begin
    sel_byte = '0;
    sel_last = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) begin
        sel_byte = sel_byte | i_req_byte[8*k +: 8];
        sel_last = sel_last | i_req_last[k];
      end
      if (pick[k]) begin
        pick_idx = pick_idx | PTR_W'(k);
      end
    end
  end

  assign sel_valid = |(i_req_valid & grant_q);
  assign ptr_next  = (gidx_q == PTR_LAST) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
    err_d   = err_q;
    if (i_err_clr) begin
      err_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = pick;
          gidx_d  = pick_idx;
          cnt_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (sel_valid) begin
          byte_d  = sel_byte;
          last_d  = sel_last;
          dv_d    = 1'b1;
          state_d = BUSY;
        end else if (cnt_q == TO_LAST) begin
          // Eviction set overrides a same-cycle clear request.
          err_d   = 1'b1;
          ptr_d   = ptr_next;
          grant_d = '0;
          state_d = IDLE;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BUSY: begin
        if (i_tx_done) begin
          if (last_q) begin
            ptr_d   = ptr_next;
            grant_d = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = '0;
            state_d = SEND;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
    end
  end

  assign o_req_ready   = (state_q == SEND) ? grant_q : '0;
  assign o_tx_dv       = dv_q;
  assign o_tx_byte     = byte_q;
  assign o_grant       = grant_q;
  assign o_busy        = (state_q != IDLE);
  assign o_timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester queues and a uart_tx done model (rev 1.0).
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int NREQ     = 4;
  localparam int TO       = 16;
  localparam int DONE_DLY = 20;
  localparam int QD       = 32;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [NREQ-1:0]     i_req_valid;
  logic [8*NREQ-1:0]   i_req_byte;
  logic [NREQ-1:0]     i_req_last;
  logic [NREQ-1:0]     o_req_ready;
  logic                o_tx_dv;
  logic [7:0]          o_tx_byte;
  logic                i_tx_done;
  logic [NREQ-1:0]     o_grant;
  logic                o_busy;
  logic                o_timeout_err;
  logic                i_err_clr;
  logic                done_model;
  logic                done_stray;

  int checks = 0;
  int errors = 0;

  logic [8:0]  rq_mem  [NREQ][QD];
  int          rq_head [NREQ] = '{default: 0};
  int          rq_tail [NREQ] = '{default: 0};
  logic [11:0] exp_tx_q[$];
  logic [3:0]  exp_grant_q[$];
  logic [NREQ-1:0] drv_hs;
  int          model_cnt;

  assign i_tx_done = done_model | done_stray;

  uart_tx_arbiter #(
    .NUM_REQ        (NREQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_req_valid   (i_req_valid),
    .i_req_byte    (i_req_byte),
    .i_req_last    (i_req_last),
    .o_req_ready   (o_req_ready),
    .o_tx_dv       (o_tx_dv),
    .o_tx_byte     (o_tx_byte),
    .i_tx_done     (i_tx_done),
    .o_grant       (o_grant),
    .o_busy        (o_busy),
    .o_timeout_err (o_timeout_err),
    .i_err_clr     (i_err_clr)
  );

  always #5 clock = ~clock;

  // Requesters: present queue heads, pop on a handshake seen at the previous negedge.
  initial begin
    i_req_valid = '0;
    i_req_byte  = '0;
    i_req_last  = '0;
    forever begin
      @(negedge clock);
      drv_hs = i_req_valid & o_req_ready;
      @(posedge clock);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (drv_hs[k] && rq_head[k] != rq_tail[k]) rq_head[k]++;
        if (rq_head[k] != rq_tail[k]) begin
          i_req_valid[k]       = 1'b1;
          i_req_byte[8*k +: 8] = rq_mem[k][rq_head[k] % QD][7:0];
          i_req_last[k]        = rq_mem[k][rq_head[k] % QD][8];
        end else begin
          i_req_valid[k]       = 1'b0;
          i_req_byte[8*k +: 8] = 8'($urandom);
          i_req_last[k]        = 1'($urandom);
        end
      end
    end
  end

  // uart_tx stand-in: done pulse DONE_DLY cycles after each DV, cleared by reset.
  initial begin
    done_model = 1'b0;
    model_cnt  = 0;
    forever begin
      @(posedge clock);
      #1;
      done_model = 1'b0;
      if (!reset_n) model_cnt = 0;
      else if (model_cnt > 0) begin
        model_cnt--;
        if (model_cnt == 0) done_model = 1'b1;
      end else if (o_tx_dv) model_cnt = DONE_DLY;
    end
  end

  initial begin : monitor
    logic            prev_dv;
    logic [NREQ-1:0] prev_g;
    logic [11:0]     e;
    logic [3:0]      eg;
    prev_dv = 1'b0;
    prev_g  = '0;
    forever begin
      @(posedge clock);
      #2;
      checks++;
      if ($countones(o_req_ready) > 1 || (o_req_ready & ~o_grant) != '0) begin
        errors++;
        $display("FAIL ready_onehot ready=%b grant=%b required at most one bit, within grant", o_req_ready, o_grant);
      end
      if (o_tx_dv) begin
        checks++;
        if (prev_dv) begin
          errors++;
          $display("FAIL dv_width dv high two cycles in a row, required single-cycle pulse");
        end else if (exp_tx_q.size() == 0) begin
          errors++;
          $display("FAIL dv_unexpected grant=%b byte=%h required no DV", o_grant, o_tx_byte);
        end else begin
          e = exp_tx_q.pop_front();
          if ({o_grant, o_tx_byte} !== e) begin
            errors++;
            $display("FAIL tx_byte grant=%b byte=%h required grant=%b byte=%h", o_grant, o_tx_byte, e[11:8], e[7:0]);
          end
        end
      end
      if (o_grant != '0 && prev_g == '0) begin
        checks++;
        if (exp_grant_q.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected grant=%b required no grant", o_grant);
        end else begin
          eg = exp_grant_q.pop_front();
          if (o_grant !== eg) begin
            errors++;
            $display("FAIL grant_order grant=%b required %b", o_grant, eg);
          end
        end
      end
      prev_dv = o_tx_dv;
      prev_g  = o_grant;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #2;
  endtask

  task automatic push_req(input int k, input logic [7:0] b, input logic l);
    rq_mem[k][rq_tail[k] % QD] = {l, b};
    rq_tail[k]++;
  endtask

  task automatic exp_tx(input logic [3:0] g, input logic [7:0] b);
    exp_tx_q.push_back({g, b});
  endtask

  task automatic exp_grant(input logic [3:0] g);
    exp_grant_q.push_back(g);
  endtask

  function automatic bit rq_all_empty();
    for (int k = 0; k < NREQ; k++) if (rq_head[k] != rq_tail[k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_quiet(input string tag);
    int n;
    bit q;
    n = 0;
    q = 1'b0;
    while (!q && n < 3000) begin
      tick;
      n++;
      q = (exp_tx_q.size() == 0) && (exp_grant_q.size() == 0) && !o_busy && rq_all_empty();
    end
    checks++;
    if (!q) begin
      errors++;
      $display("FAIL %s_drain busy=%b pending_tx=%0d pending_grant=%0d required all drained",
               tag, o_busy, exp_tx_q.size(), exp_grant_q.size());
    end
  endtask

  task automatic test_reset;
    tick;
    checks++;
    if ({o_grant, o_busy, o_tx_dv} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl grant=%b busy=%b dv=%b required 0", o_grant, o_busy, o_tx_dv);
    end
    checks++;
    if (o_tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_byte byte=%h required 00", o_tx_byte);
    end
    checks++;
    if ({o_req_ready, o_timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ready_err ready=%b err=%b required 0", o_req_ready, o_timeout_err);
    end
    reset_n = 1'b1;
    tick;
    tick;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_round_robin;
    int n, seen;
    logic [3:0] prev, owner;
    push_req(0, 8'h10, 1'b1); push_req(0, 8'h11, 1'b1);
    push_req(2, 8'h20, 1'b1); push_req(2, 8'h21, 1'b1);
    push_req(3, 8'h30, 1'b1);
    exp_tx(4'b0001, 8'h10); exp_tx(4'b0100, 8'h20); exp_tx(4'b1000, 8'h30);
    exp_tx(4'b0001, 8'h11); exp_tx(4'b0100, 8'h21);
    exp_grant(4'b0001); exp_grant(4'b0100); exp_grant(4'b1000);
    exp_grant(4'b0001); exp_grant(4'b0100);
    n = 0; seen = 0; prev = '0; owner = '0;
    while (seen < 5 && n < 2000) begin
      tick;
      n++;
      if (o_grant != '0 && prev == '0) begin
        seen++;
        checks++;
        if (o_grant === owner) begin
          errors++;
          $display("FAIL rr_repeat grant=%b required a different owner than %b", o_grant, owner);
        end
        owner = o_grant;
      end
      prev = o_grant;
    end
    checks++;
    if (seen != 5) begin
      errors++;
      $display("FAIL rr_grant_count grants=%0d required 5", seen);
    end
    wait_quiet("rr");
  endtask

  task automatic test_single_packet;
    int n, dones, first_dv, second_dv, done1;
    bit grant_bad;
    push_req(1, 8'hA5, 1'b0);
    push_req(1, 8'h3C, 1'b1);
    exp_tx(4'b0010, 8'hA5); exp_tx(4'b0010, 8'h3C);
    exp_grant(4'b0010);
    n = 0; dones = 0; first_dv = -1; second_dv = -1; done1 = -1; grant_bad = 1'b0;
    while (dones < 2 && n < 500) begin
      tick;
      n++;
      if (o_busy && o_grant !== 4'b0010) grant_bad = 1'b1;
      if (o_tx_dv) begin
        if (first_dv < 0) first_dv = n;
        else second_dv = n;
      end
      if (done_model) begin
        dones++;
        if (dones == 1) done1 = n;
      end
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL sp_done_count dones=%0d required 2", dones);
    end
    checks++;
    if (grant_bad) begin
      errors++;
      $display("FAIL sp_grant grant left 0010 during packet, required 0010 throughout");
    end
    checks++;
    if (first_dv != 3) begin
      errors++;
      $display("FAIL sp_first_dv_latency cycles=%0d required 3", first_dv);
    end
    checks++;
    if (second_dv != done1 + 2) begin
      errors++;
      $display("FAIL sp_next_dv_latency dv_at=%0d required %0d", second_dv, done1 + 2);
    end
    tick;
    checks++;
    if (o_busy !== 1'b0 || o_grant !== 4'b0000) begin
      errors++;
      $display("FAIL sp_idle_after_last busy=%b grant=%b required 0 0", o_busy, o_grant);
    end
    wait_quiet("sp");
  endtask

  task automatic test_stray_done;
    int n;
    bit bad;
    tick;
    done_stray = 1'b1;
    tick;
    done_stray = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_tx_dv !== 1'b0 || o_grant !== 4'b0) begin
      errors++;
      $display("FAIL stray_idle busy=%b dv=%b grant=%b required 0 0 0", o_busy, o_tx_dv, o_grant);
    end
    push_req(1, 8'h5A, 1'b0);
    exp_tx(4'b0010, 8'h5A); exp_tx(4'b0010, 8'h96);
    exp_grant(4'b0010);
    n = 0;
    while (!done_model && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (!done_model) begin
      errors++;
      $display("FAIL stray_first_done no done observed, required one within 200 cycles");
    end
    tick;
    checks++;
    if (o_req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL stray_send_entry ready=%b required 0010", o_req_ready);
    end
    done_stray = 1'b1;
    bad = 1'b0;
    repeat (3) begin
      tick;
      if (o_busy !== 1'b1 || o_req_ready !== 4'b0010 || o_tx_dv !== 1'b0) bad = 1'b1;
    end
    done_stray = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stray_send busy=%b ready=%b dv=%b required SEND held with ready 0010, no DV",
               o_busy, o_req_ready, o_tx_dv);
    end
    push_req(1, 8'h96, 1'b1);
    wait_quiet("stray");
  endtask

  task automatic test_packet_lock;
    int n, dones;
    bit bad;
    push_req(0, 8'hC1, 1'b0); push_req(0, 8'hC2, 1'b0); push_req(0, 8'hC3, 1'b1);
    exp_tx(4'b0001, 8'hC1); exp_tx(4'b0001, 8'hC2); exp_tx(4'b0001, 8'hC3);
    exp_tx(4'b1000, 8'hD4);
    exp_grant(4'b0001); exp_grant(4'b1000);
    n = 0;
    while (o_grant !== 4'b0001 && n < 50) begin
      tick;
      n++;
    end
    push_req(3, 8'hD4, 1'b1);
    n = 0; dones = 0; bad = 1'b0;
    while (dones < 3 && n < 500) begin
      tick;
      n++;
      if (o_req_ready[3] !== 1'b0) bad = 1'b1;
      if (done_model) dones++;
    end
    checks++;
    if (dones != 3) begin
      errors++;
      $display("FAIL lock_done_count dones=%0d required 3", dones);
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL lock_ready3 ready[3] went high mid-packet, required 0");
    end
    tick;
    checks++;
    if (o_grant !== 4'b0000 || o_req_ready[3] !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle grant=%b ready=%b required 0000 0000", o_grant, o_req_ready);
    end
    tick;
    checks++;
    if (o_grant !== 4'b1000) begin
      errors++;
      $display("FAIL lock_next_grant grant=%b required 1000", o_grant);
    end
    wait_quiet("lock");
  endtask

  task automatic test_timeout;
    int n;
    push_req(2, 8'h77, 1'b0);
    push_req(3, 8'h88, 1'b1);
    exp_tx(4'b0100, 8'h77); exp_tx(4'b1000, 8'h88);
    exp_grant(4'b0100); exp_grant(4'b1000);
    n = 0;
    while (!done_model && n < 200) begin
      tick;
      n++;
    end
    checks++;
    if (!done_model) begin
      errors++;
      $display("FAIL to_first_done no done observed, required one within 200 cycles");
    end
    tick;
    checks++;
    if (o_req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL to_send_entry ready=%b required 0100", o_req_ready);
    end
    repeat (14) tick;
    checks++;
    if (o_busy !== 1'b1 || o_timeout_err !== 1'b0 || o_grant !== 4'b0100) begin
      errors++;
      $display("FAIL to_early busy=%b err=%b grant=%b required 1 0 0100", o_busy, o_timeout_err, o_grant);
    end
    i_err_clr = 1'b1;
    tick;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL to_cycle15 busy=%b required 1", o_busy);
    end
    tick;
    i_err_clr = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_grant !== 4'b0000 || o_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_evict busy=%b grant=%b err=%b required 0 0000 1", o_busy, o_grant, o_timeout_err);
    end
    wait_quiet("to");
    checks++;
    if (o_timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky err=%b required 1", o_timeout_err);
    end
    i_err_clr = 1'b1;
    tick;
    i_err_clr = 1'b0;
    checks++;
    if (o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL to_clear err=%b required 0", o_timeout_err);
    end
  endtask

  task automatic test_reset_mid_busy;
    int n;
    push_req(1, 8'h11, 1'b1);
    exp_tx(4'b0010, 8'h11);
    exp_grant(4'b0010);
    wait_quiet("rst_pre");
    push_req(2, 8'h22, 1'b1);
    exp_tx(4'b0100, 8'h22);
    exp_grant(4'b0100);
    n = 0;
    while (!o_tx_dv && n < 50) begin
      tick;
      n++;
    end
    repeat (3) tick;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_busy_before busy=%b required 1", o_busy);
    end
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (o_grant !== 4'b0 || o_busy !== 1'b0 || o_req_ready !== 4'b0) begin
      errors++;
      $display("FAIL rst_async_ctrl grant=%b busy=%b ready=%b required 0", o_grant, o_busy, o_req_ready);
    end
    checks++;
    if (o_tx_dv !== 1'b0 || o_tx_byte !== 8'h00 || o_timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_data dv=%b byte=%h err=%b required 0 00 0", o_tx_dv, o_tx_byte, o_timeout_err);
    end
    repeat (2) @(posedge clock);
    #2;
    reset_n = 1'b1;
    push_req(0, 8'hA0, 1'b1);
    push_req(3, 8'hB0, 1'b1);
    exp_tx(4'b0001, 8'hA0); exp_tx(4'b1000, 8'hB0);
    exp_grant(4'b0001); exp_grant(4'b1000);
    wait_quiet("rst_post");
  endtask

  initial begin
    done_stray = 1'b0;
    i_err_clr  = 1'b0;
    test_reset;
    test_round_robin;
    test_single_packet;
    test_stray_done;
    test_packet_lock;
    test_timeout;
    test_reset_mid_busy;
    checks++;
    if (exp_tx_q.size() != 0 || exp_grant_q.size() != 0) begin
      errors++;
      $display("FAIL leftover pending_tx=%0d pending_grant=%0d required 0 0", exp_tx_q.size(), exp_grant_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among up to NUM_REQ byte-stream requesters: RX echo, the AES result stream and a status reporter. The block sits between the requester sources and the `uart_tx` instance in the top level, which it drives through that instance's DV/byte/done port set. Arbitration is round-robin at packet granularity, so a granted requester keeps the transmitter until it sends a byte marked last. A stalled requester is evicted after a timeout.

## Interface
- NUM_REQ, 4 — number of requesters, 2..8.
- TIMEOUT_CYCLES, 4096 — idle cycles tolerated mid-packet before eviction, 2..65535.
- clock  in  1  system clock, 100 MHz.
- reset_n  in  1  reset. Asynchronous assert, active-low; release is synchronous to `clock`.
- i_req_valid  in  NUM_REQ  per-requester byte valid.
- i_req_byte  in  8*NUM_REQ  per-requester byte; requester k occupies bits [8k+7:8k].
- i_req_last  in  NUM_REQ  current byte ends the packet.
- o_req_ready  out  NUM_REQ  per-requester accept, at most one bit high.
- o_tx_dv  out  1  one-cycle start pulse to `uart_tx`.
- o_tx_byte  out  8  byte to `uart_tx`, held stable until the next load.
- i_tx_done  in  1  `uart_tx` done pulse.
- o_grant  out  NUM_REQ  one-hot current owner; zero when IDLE.
- o_busy  out  1  state is not IDLE.
- o_timeout_err  out  1  sticky eviction flag.
- i_err_clr  in  1  clears `o_timeout_err`.

## Operation
- FSM states are IDLE, SEND and BUSY.
- **IDLE**
  - If any `i_req_valid` is high, select the first requester at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Register the selection into `o_grant`, clear the timeout counter and go to SEND.
- **SEND**
  - `o_req_ready[g] = 1` for the granted requester g, decoded from registered state only.
  - A transfer occurs when valid and ready are both high in the same cycle.
  - On a transfer: latch the byte into `o_tx_byte`, latch `last` into `last_q`, pulse `o_tx_dv` on the next cycle and go to BUSY.
  - With no transfer, the timeout counter increments. When it reaches TIMEOUT_CYCLES-1:
    - set `o_timeout_err`;
    - set `rr_ptr = (g+1) mod NUM_REQ`;
    - clear `o_grant` and go to IDLE.
- **BUSY**
  - Wait for `i_tx_done`.
  - If `last_q` is set, set `rr_ptr = (g+1) mod NUM_REQ`, clear `o_grant` and go to IDLE.
  - Otherwise clear the timeout counter and go to SEND.
- Reset values: all outputs 0, `o_tx_byte` = 8'h00, `rr_ptr` = 0, state IDLE, counter 0, `last_q` 0.
- Boundary conditions:
  - `i_tx_done` received in IDLE or SEND is ignored.
  - `o_tx_dv` never asserts while in BUSY, so there is at most one byte in flight.
  - Requests from non-granted requesters are held off by ready = 0; there is no preemption.
  - If `i_err_clr` is asserted in the same cycle as a new timeout, the set wins.
  - `i_req_byte` and `i_req_last` are sampled only on a transfer.
- Reset mid-packet aborts the packet. `uart_tx` shares the system reset, so no stale done pulse follows.
- Timeout counter is 16 bits and saturates; it never wraps.

## Timing
- Request to grant: `i_req_valid` rising in IDLE at cycle 0 gives SEND with `o_grant` valid at cycle 1.
- Ready to transfer: ready is high from cycle 1, so the earliest transfer is at cycle 1.
- Transfer to `uart_tx`: `o_tx_dv` is high for exactly one cycle at cycle 2, with `o_tx_byte` stable from cycle 2.
- Done to next byte: `i_tx_done` at cycle d gives SEND at d+1, and the next `o_tx_dv` is at d+2 at the earliest.
- Done on last byte: `i_tx_done` at cycle d gives IDLE at d+1, and a new grant at d+2.
- Per-byte overhead is 2 clocks plus the UART frame (10 × 868 clocks at 115200 baud).
- Timeout on a silent requester: eviction occurs TIMEOUT_CYCLES cycles after SEND entry.

## Structure
- Package `uart_arb_pkg` holds:
  - the state enum: IDLE = 2'd0, SEND = 2'd1, BUSY = 2'd2;
  - `CLKS_PER_BIT = 16'd868`;
  - the default NUM_REQ and TIMEOUT_CYCLES.
- Sub-module `rr_pick` is combinational. It takes the request vector and `rr_ptr` and returns a one-hot pick plus an any-request flag. It is reusable by other shared-resource blocks.
- Top-level integration:
  - replaces the direct RX→TX echo register;
  - the echo path becomes requester 0, with `last` = 1 on every byte.

## Test plan
- **Single packet:** requester 1 sends bytes 8'hA5 then 8'h3C (last), with `i_tx_done` modelled 20 cycles after each DV.
  - Required: `o_grant` = 4'b0010 throughout.
  - Required: two DV pulses carrying A5 then 3C.
  - Required: return to IDLE one cycle after the second done.
- **Round-robin:** requesters 0, 2 and 3 request continuously with 1-byte packets.
  - Required: grant order 0, 2, 3, 0, 2, with no requester granted twice in a row.
- **Packet lock:** requester 3 asserts valid while requester 0 is mid-packet (3 bytes).
  - Required: `o_req_ready[3]` stays 0 until requester 0's last byte is done.
  - Required: requester 3 is then granted.
- **Timeout:** TIMEOUT_CYCLES = 16; requester 2 sends one non-last byte, then drops valid.
  - Required: eviction 16 cycles after SEND re-entry, with `o_timeout_err` = 1.
  - Required: next grant goes to requester 3 if it is requesting.
  - Required: `i_err_clr` then clears the flag.
- **Reset mid-BUSY:** pull `reset_n` low asynchronously between clock edges.
  - Required: all outputs go to 0 immediately and state is IDLE.
  - Required: after release, requester 0 has first priority.
- **Stray done:** pulse `i_tx_done` in IDLE and in SEND.
  - Required: no state change and no DV.
